// File: rtl/dvp_frame_scheduler.sv
// rtl/dvp_frame_scheduler.sv - frame buffer ring scheduler for DVP capture (optional drop counter: DVP_FRAME_SCHED_DROP_CNT_EN)
`timescale 1ns/1ps
module dvp_frame_scheduler #(
   parameter int ADDR_W      = 32,
   parameter int NUM_BUF     = 3,
   parameter int BURST_BYTES = 512,
   parameter int MAX_OUTST   = 4,
   parameter int BURST_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_start_i,
   input  logic [ADDR_W-1:0]      cfg_base_i,
   input  logic [ADDR_W-1:0]      cfg_stride_i,
   input  logic [BURST_CNT_W-1:0] cfg_frame_bursts_i,
   input  logic                   sof_i,
   input  logic                   baddr_rdy_i,
   output logic [ADDR_W-1:0]      baddr_o,
   output logic                   baddr_vld_o,
   input  logic                   bdone_i,
   input  logic                   berr_i,
   input  logic                   rel_vld_i,
   input  logic [1:0]             rel_idx_i,
   output logic                   pxl_en_o,
   output logic                   frame_done_o,
   output logic [1:0]             frame_idx_o,
   output logic                   frame_err_o,
   output logic [NUM_BUF-1:0]     buf_full_o,
   output logic                   busy_o
`ifdef DVP_FRAME_SCHED_DROP_CNT_EN
   ,
   output logic [15:0]            drop_cnt_o
`endif
);

   localparam int OUT_W = 4;
   localparam logic [2:0] NB = 3'(NUM_BUF);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_SKIP, S_ACTIVE, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             wptr_q, wptr_d;
   logic [1:0]             idx_q, idx_d;
   logic [BURST_CNT_W-1:0] issued_q, issued_d;
   logic [BURST_CNT_W-1:0] bursts_q, bursts_d;
   logic [OUT_W-1:0]       outst_q, outst_d;
   logic                   err_q, err_d;
   logic [NUM_BUF-1:0]     full_q, full_d;
   logic [ADDR_W-1:0]      baddr_q, baddr_d;

   logic [3:0] full4;
   logic [3:0] full_nxt;
   logic [2:0] cand;
   logic       found;
   logic [1:0] sel;
   logic       sof_eval, frame_start, frame_drop, handshake, resp_dec, done;

   // free-buffer search starting at the write pointer, wrapping modulo NUM_BUF
   always_comb begin
      full4 = '0;
      full4[NUM_BUF-1:0] = full_q;
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_BUF; k++) begin
         cand = {1'b0, wptr_q} + 3'(k);
         if (cand >= NB) cand = cand - NB;
         if (!found && !full4[cand[1:0]]) begin
            found = 1'b1;
            sel   = cand[1:0];
         end
      end
   end

   // frame-level events shared by the FSM and the datapath
   always_comb begin
      sof_eval    = (state_q == S_WAIT_SOF || state_q == S_SKIP) && cfg_start_i && sof_i;
      frame_start = sof_eval && found;
      frame_drop  = sof_eval && !found;
      handshake   = baddr_vld_o && baddr_rdy_i;
      resp_dec    = bdone_i && (outst_q != '0);
      done        = (state_q == S_DRAIN) && (outst_q == '0);
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cfg_start_i) state_d = S_WAIT_SOF;
         S_WAIT_SOF, S_SKIP: begin
            if (!cfg_start_i)  state_d = S_IDLE;
            else if (sof_i)    state_d = found ? S_ACTIVE : S_SKIP;
         end
         S_ACTIVE: if (handshake && (issued_q + BURST_CNT_W'(1) == bursts_q)) state_d = S_DRAIN;
         S_DRAIN:  if (outst_q == '0) state_d = cfg_start_i ? S_WAIT_SOF : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // outputs decoded from state and registered counters
   always_comb begin
      pxl_en_o     = (state_q == S_ACTIVE);
      baddr_vld_o  = (state_q == S_ACTIVE) && (issued_q < bursts_q) &&
                     (outst_q < OUT_W'(MAX_OUTST));
      frame_done_o = done;
      busy_o       = (state_q != S_IDLE);
      baddr_o      = baddr_q;
      frame_idx_o  = idx_q;
      frame_err_o  = err_q;
      buf_full_o   = full_q;
   end

   // per-frame counters, address generator, ownership flags and write pointer
   always_comb begin
      idx_d    = idx_q;
      issued_d = issued_q;
      bursts_d = bursts_q;
      outst_d  = outst_q;
      err_d    = err_q;
      baddr_d  = baddr_q;
      wptr_d   = wptr_q;
      full_nxt = full4;

      if (frame_start) begin
         idx_d    = sel;
         issued_d = '0;
         outst_d  = '0;
         err_d    = 1'b0;
         bursts_d = (cfg_frame_bursts_i == '0) ? BURST_CNT_W'(1) : cfg_frame_bursts_i;
         baddr_d  = cfg_base_i + ADDR_W'(sel) * cfg_stride_i;
      end else begin
         if (handshake) begin
            issued_d = issued_q + BURST_CNT_W'(1);
            baddr_d  = baddr_q + ADDR_W'(BURST_BYTES);
         end
         // a handshake and a response in the same cycle cancel out
         if (handshake && !resp_dec)      outst_d = outst_q + OUT_W'(1);
         else if (!handshake && resp_dec) outst_d = outst_q - OUT_W'(1);
         if (resp_dec && berr_i) err_d = 1'b1;
      end

      // release first so a same-cycle completion on that index keeps the buffer
      if (rel_vld_i && ({1'b0, rel_idx_i} < NB)) full_nxt[rel_idx_i] = 1'b0;
      if (done) begin
         full_nxt[idx_q] = 1'b1;
         wptr_d = ({1'b0, idx_q} == NB - 3'd1) ? 2'd0 : idx_q + 2'd1;
      end
      full_d = full_nxt[NUM_BUF-1:0];
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wptr_q   <= '0;
         idx_q    <= '0;
         issued_q <= '0;
         bursts_q <= '0;
         outst_q  <= '0;
         err_q    <= 1'b0;
         full_q   <= '0;
         baddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         idx_q    <= idx_d;
         issued_q <= issued_d;
         bursts_q <= bursts_d;
         outst_q  <= outst_d;
         err_q    <= err_d;
         full_q   <= full_d;
         baddr_q  <= baddr_d;
      end
   end

`ifdef DVP_FRAME_SCHED_DROP_CNT_EN
   logic        start_q, start_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // saturating dropped-frame count, cleared when capture is (re)enabled
   always_comb begin
      start_d    = cfg_start_i;
      drop_cnt_d = drop_cnt_q;
      if (cfg_start_i && !start_q)
         drop_cnt_d = '0;
      else if (frame_drop && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
   end

   // drop counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q    <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         start_q    <= start_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   // dropped frames are discarded without being counted
`endif

endmodule

// File: tb/tb_dvp_frame_scheduler.sv
// tb/tb_dvp_frame_scheduler.sv - self-checking bench for dvp_frame_scheduler
`timescale 1ns/1ps
module tb_dvp_frame_scheduler;

   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam logic [31:0] STRIDE = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start_i = 1'b0;
   logic [31:0] cfg_base_i = BASE;
   logic [31:0] cfg_stride_i = STRIDE;
   logic [15:0] cfg_frame_bursts_i = 16'd4;
   logic        sof_i = 1'b0;
   logic        baddr_rdy_i = 1'b0;
   logic [31:0] baddr_o;
   logic        baddr_vld_o;
   logic        bdone_i = 1'b0;
   logic        berr_i = 1'b0;
   logic        rel_vld_i = 1'b0;
   logic [1:0]  rel_idx_i = 2'd0;
   logic        pxl_en_o, frame_done_o, frame_err_o, busy_o;
   logic [1:0]  frame_idx_o;
   logic [2:0]  buf_full_o;
`ifdef DVP_FRAME_SCHED_DROP_CNT_EN
   logic [15:0] drop_cnt_o;
`endif

   dvp_frame_scheduler dut (
      .clk(clk), .rst(rst), .cfg_start_i(cfg_start_i), .cfg_base_i(cfg_base_i),
      .cfg_stride_i(cfg_stride_i), .cfg_frame_bursts_i(cfg_frame_bursts_i),
      .sof_i(sof_i), .baddr_rdy_i(baddr_rdy_i), .baddr_o(baddr_o),
      .baddr_vld_o(baddr_vld_o), .bdone_i(bdone_i), .berr_i(berr_i),
      .rel_vld_i(rel_vld_i), .rel_idx_i(rel_idx_i), .pxl_en_o(pxl_en_o),
      .frame_done_o(frame_done_o), .frame_idx_o(frame_idx_o),
      .frame_err_o(frame_err_o), .buf_full_o(buf_full_o), .busy_o(busy_o)
`ifdef DVP_FRAME_SCHED_DROP_CNT_EN
      , .drop_cnt_o(drop_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // scoreboard of expected burst addresses, filled by the stimulus side
   logic [31:0] exp_addr[$];
   // response timing, owned by the responder process
   int resp_due[$];
   int cyc = 0;
   int hs_count = 0;
   int resp_total = 0;
   // responder controls, owned by the stimulus process
   int rdy_mode = 0;
   bit hold_b = 1'b0;
   int b_allow = 0;
   int err_target = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // responder/monitor: drives rdy and B pulses, checks each handshake against the scoreboard
   initial begin : responder
      bit          stall_prev;
      logic [31:0] stall_addr;
      stall_prev = 1'b0;
      stall_addr = '0;
      forever begin
         @(negedge clk);
         cyc++;
         case (rdy_mode)
            0:       baddr_rdy_i = 1'b1;
            1:       baddr_rdy_i = 1'($urandom_range(0, 1));
            default: baddr_rdy_i = 1'b0;
         endcase
         if (resp_due.size() > 0 && resp_due[0] <= cyc && (!hold_b || resp_total < b_allow)) begin
            void'(resp_due.pop_front());
            resp_total++;
            bdone_i = 1'b1;
            berr_i  = (resp_total == err_target);
         end else begin
            bdone_i = 1'b0;
            berr_i  = 1'b0;
         end
         #2;
         if (stall_prev && baddr_vld_o)
            check("addr_stable_on_stall", baddr_o, stall_addr);
         stall_prev = baddr_vld_o && !baddr_rdy_i;
         stall_addr = baddr_o;
         if (baddr_vld_o && baddr_rdy_i) begin
            hs_count++;
            resp_due.push_back(cyc + 3);
            if (exp_addr.size() == 0)
               check("unexpected_handshake", baddr_o, 64'hFFFF_FFFF_FFFF_FFFF);
            else
               check("burst_addr", baddr_o, exp_addr.pop_front());
         end
      end
   end

   typedef struct {
      bit          rel;
      logic [1:0]  rel_idx;
      logic [15:0] bursts;
      int          err_at;
      bit          cap;
      logic [1:0]  idx;
      bit          err;
      logic [2:0]  full;
      int          drops;
   } vec_t;

   vec_t vecs[7];

   task automatic push_addrs(input logic [1:0] idx, input logic [15:0] bursts);
      int n;
      n = (bursts == 16'd0) ? 1 : int'(bursts);
      for (int k = 0; k < n; k++)
         exp_addr.push_back(BASE + 32'(idx) * STRIDE + 32'(k) * 32'd512);
   endtask

   task automatic pulse_sof();
      @(negedge clk); sof_i = 1'b1;
      @(negedge clk); sof_i = 1'b0;
   endtask

   task automatic wait_done(input logic [1:0] idx, input bit err);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk); #2;
         if (frame_done_o) seen = 1'b1;
      end
      check("frame_done_seen", seen, 1);
      check("frame_idx", frame_idx_o, idx);
      check("frame_err", frame_err_o, err);
      check("all_addrs_issued", exp_addr.size(), 0);
   endtask

   task automatic check_drop();
      bit ok;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk); #2;
         if (baddr_vld_o || pxl_en_o) ok = 1'b0;
      end
      check("drop_no_capture", ok, 1);
      check("drop_busy", busy_o, 1);
   endtask

   task automatic run_vec(input vec_t v);
      if (v.rel) begin
         @(negedge clk); rel_vld_i = 1'b1; rel_idx_i = v.rel_idx;
         @(negedge clk); rel_vld_i = 1'b0;
      end
      cfg_frame_bursts_i = v.bursts;
      err_target = (v.err_at == 0) ? -1 : resp_total + v.err_at;
      if (v.cap) push_addrs(v.idx, v.bursts);
      pulse_sof();
      if (v.cap) wait_done(v.idx, v.err);
      else       check_drop();
      @(negedge clk); #2;
      check("buf_full", buf_full_o, v.full);
`ifdef DVP_FRAME_SCHED_DROP_CNT_EN
      check("drop_cnt", drop_cnt_o, v.drops);
`endif
   endtask

   initial begin : stimulus
      int h0;
      bit reached;
      //          rel   ridx   bursts  err cap  idx    err   full    drops
      vecs[0] = '{1'b0, 2'd0, 16'd4, 0, 1'b1, 2'd0, 1'b0, 3'b001, 0};
      vecs[1] = '{1'b0, 2'd0, 16'd2, 2, 1'b1, 2'd1, 1'b1, 3'b011, 0};
      vecs[2] = '{1'b0, 2'd0, 16'd0, 0, 1'b1, 2'd2, 1'b0, 3'b111, 0};
      vecs[3] = '{1'b0, 2'd0, 16'd4, 0, 1'b0, 2'd0, 1'b0, 3'b111, 1};
      vecs[4] = '{1'b1, 2'd1, 16'd4, 0, 1'b1, 2'd1, 1'b0, 3'b111, 1};
      vecs[5] = '{1'b1, 2'd3, 16'd4, 0, 1'b0, 2'd0, 1'b0, 3'b111, 2};
      vecs[6] = '{1'b1, 2'd0, 16'd3, 0, 1'b1, 2'd0, 1'b0, 3'b111, 2};

      // reset values
      repeat (3) @(negedge clk);
      #2;
      check("rst_pxl_en", pxl_en_o, 0);
      check("rst_vld", baddr_vld_o, 0);
      check("rst_baddr", baddr_o, 0);
      check("rst_done", frame_done_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_full", buf_full_o, 0);
      check("rst_idx", frame_idx_o, 0);
      check("rst_err", frame_err_o, 0);
`ifdef DVP_FRAME_SCHED_DROP_CNT_EN
      check("rst_drop_cnt", drop_cnt_o, 0);
`endif
      @(negedge clk); rst = 1'b0; cfg_start_i = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      check("busy_after_start", busy_o, 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // release every buffer, then throttle by withholding B responses
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); rel_vld_i = 1'b1; rel_idx_i = 2'(i);
      end
      @(negedge clk); rel_vld_i = 1'b0;
      #2;
      check("release_all", buf_full_o, 0);
      hold_b = 1'b1;
      b_allow = resp_total;
      err_target = -1;
      cfg_frame_bursts_i = 16'd8;
      push_addrs(2'd1, 16'd8);
      h0 = hs_count;
      pulse_sof();
      repeat (15) @(negedge clk);
      #2;
      check("outst_limit_hs", hs_count - h0, 4);
      check("outst_limit_vld", baddr_vld_o, 0);
      b_allow = resp_total + 1;
      repeat (10) @(negedge clk);
      #2;
      check("one_more_hs", hs_count - h0, 5);
      check("one_more_vld", baddr_vld_o, 0);
      hold_b = 1'b0;
      wait_done(2'd1, 1'b0);
      @(negedge clk); #2;
      check("full_after_throttle", buf_full_o, 3'b010);

      // random ready back-pressure
      rdy_mode = 1;
      cfg_frame_bursts_i = 16'd6;
      push_addrs(2'd2, 16'd6);
      pulse_sof();
      wait_done(2'd2, 1'b0);
      rdy_mode = 0;
      @(negedge clk); #2;
      check("full_after_random", buf_full_o, 3'b110);

      // reset in the middle of a frame after two bursts
      cfg_frame_bursts_i = 16'd8;
      push_addrs(2'd0, 16'd8);
      h0 = hs_count;
      pulse_sof();
      reached = 1'b0;
      for (int i = 0; i < 50 && !reached; i++) begin
         @(negedge clk); #2;
         if (hs_count - h0 >= 2) reached = 1'b1;
      end
      rdy_mode = 2;
      check("pre_rst_two_bursts", reached, 1);
      @(negedge clk); rst = 1'b1;
      #2;
      check("mid_rst_pxl_en", pxl_en_o, 0);
      check("mid_rst_vld", baddr_vld_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_baddr", baddr_o, 0);
      check("mid_rst_full", buf_full_o, 0);
      check("mid_rst_idx", frame_idx_o, 0);
      exp_addr.delete();
      @(negedge clk); rst = 1'b0; rdy_mode = 0;
      repeat (6) @(negedge clk);
      cfg_frame_bursts_i = 16'd4;
      push_addrs(2'd0, 16'd4);
      pulse_sof();
      wait_done(2'd0, 1'b0);
      @(negedge clk); #2;
      check("full_after_rst_frame", buf_full_o, 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
